// File: rtl/huff_tree_builder.sv
// Huffman tree builder: five min-pair merges over six symbol counts into a node table.
// Optional HUFF_TREE_WEIGHT_EN adds the root_weight output.
module huff_tree_builder #(
  parameter int CNT_W = 8,
  parameter int SUM_W = CNT_W + 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6*CNT_W-1:0] cnt_in,
  input  logic               cnt_valid,
  input  logic [3:0]         root_sel,
  output logic [3:0]         node_l_sel,
  output logic [3:0]         node_r_sel,
  output logic               cmb_cmp_flg,
  output logic               busy
`ifdef HUFF_TREE_WEIGHT_EN
  ,output logic [SUM_W-1:0]  root_weight
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, FIND, MERGE, DONE} state_t;
  localparam logic [3:0] NODE_EMPTY = 4'd11;

  state_t           state, state_nx;
  logic [3:0]       slot_id  [6];
  logic [SUM_W-1:0] slot_w   [6];
  logic [5:0]       slot_act;
  logic [3:0]       tab_l    [5];
  logic [3:0]       tab_r    [5];
  logic [2:0]       min1, min2, min1_nx, min2_nx;
  logic [2:0]       round;
  logic             found1, found2;
  logic             accept;
  logic [SUM_W-1:0] merge_w;
  logic [3:0]       new_id;
  logic [2:0]       tab_idx;
  logic [2:0]       sel_idx;

  // Ordering key: lower weight first; on equal weight the higher node id ranks smaller.
  function automatic logic ranks_below(input logic [SUM_W-1:0] wa, input logic [3:0] ia,
                                       input logic [SUM_W-1:0] wb, input logic [3:0] ib);
    return (wa < wb) || ((wa == wb) && (ia > ib));
  endfunction

  assign accept  = cnt_valid && ((state == IDLE) || (state == DONE));
  assign busy    = (state == LOAD) || (state == FIND) || (state == MERGE);
  assign merge_w = slot_w[min1] + slot_w[min2];
  assign new_id  = 4'd10 - {1'b0, round};
  assign tab_idx = 3'd4 - round;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (cnt_valid) state_nx = LOAD;
      LOAD:       state_nx = FIND;
      FIND:       state_nx = MERGE;
      MERGE:      state_nx = (round == 3'd4) ? DONE : FIND;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    min1_nx = '0;
    min2_nx = '0;
    found1  = 1'b0;
    found2  = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (slot_act[i] && (!found1 ||
          ranks_below(slot_w[i], slot_id[i], slot_w[min1_nx], slot_id[min1_nx]))) begin
        min1_nx = 3'(i);
        found1  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < 6; i++) begin
      if (slot_act[i] && (3'(i) != min1_nx) && (!found2 ||
          ranks_below(slot_w[i], slot_id[i], slot_w[min2_nx], slot_id[min2_nx]))) begin
        min2_nx = 3'(i);
        found2  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cmb_cmp_flg <= 1'b0;
      round       <= '0;
      min1        <= '0;
      min2        <= '0;
      slot_act    <= '0;
      for (int unsigned i = 0; i < 6; i++) begin
        slot_id[i] <= '0;
        slot_w[i]  <= '0;
      end
      for (int unsigned i = 0; i < 5; i++) begin
        tab_l[i] <= NODE_EMPTY;
        tab_r[i] <= NODE_EMPTY;
      end
    end else begin
      state <= state_nx;
      // The capture and table clear happen on the accepting edge; LOAD itself only advances.
      if (accept) begin
        cmb_cmp_flg <= 1'b0;
        round       <= '0;
        slot_act    <= '1;
        for (int unsigned i = 0; i < 6; i++) begin
          slot_id[i] <= 4'(i);
          slot_w[i]  <= SUM_W'(cnt_in[i*CNT_W +: CNT_W]);
        end
        for (int unsigned i = 0; i < 5; i++) begin
          tab_l[i] <= NODE_EMPTY;
          tab_r[i] <= NODE_EMPTY;
        end
      end else if (state == FIND) begin
        min1 <= min1_nx;
        min2 <= min2_nx;
      end else if (state == MERGE) begin
        tab_l[tab_idx]   <= slot_id[min1];
        tab_r[tab_idx]   <= slot_id[min2];
        slot_id[min1]    <= new_id;
        slot_w[min1]     <= merge_w;
        slot_act[min2]   <= 1'b0;
        round            <= round + 3'd1;
        if (round == 3'd4) cmb_cmp_flg <= 1'b1;
      end
    end
  end

`ifdef HUFF_TREE_WEIGHT_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      root_weight <= '0;
    end else if ((state == MERGE) && (round == 3'd4)) begin
      root_weight <= merge_w;
    end
  end
`else
`endif

  always_comb begin
    node_l_sel = NODE_EMPTY;
    node_r_sel = NODE_EMPTY;
    sel_idx    = 3'(root_sel - 4'd6);
    if ((root_sel >= 4'd6) && (root_sel <= 4'd10)) begin
      node_l_sel = tab_l[sel_idx];
      node_r_sel = tab_r[sel_idx];
    end
  end

endmodule
